key_filter_bank: RTL

- Input-side companion to the board LED drivers: reads NUM_KEYS raw active-low push-buttons, synchronises and debounces each one, and emits clean level and one-cycle event strobes.
- Sits between the board key pins and the LED/pattern control logic.
- Each key is an independent 4-state FSM with its own filter counter.

---
 rtl/key_filter_pkg.sv | 23 ++
 rtl/key_filter_bank_if.sv | 26 ++
 rtl/key_filter_chan.sv | 128 ++++++++++++
 rtl/key_filter_bank.sv | 45 ++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// key_filter_pkg: shared types and widths for the key debounce bank.
//   key_state_e : per-key debounce FSM encoding
//   key_evt_t   : per-key registered outputs (level + strobes)
package key_filter_pkg;

    localparam int unsigned CNT_W  = 24;
    localparam int unsigned LONG_W = 26;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } key_state_e;

    typedef struct packed {
        logic lvl;    // debounced level, 1 = pressed
        logic press;  // one-cycle press strobe
        logic rls;    // one-cycle release strobe
        logic lng;    // one-cycle long-press strobe
    } key_evt_t;

endpackage

// File: rtl/key_filter_bank_if.sv
// key_filter_bank_if: raw key pins and debounced key outputs.
//   key_in      : raw active-low key pins (driven by board / master)
//   key_state   : debounced level, 1 = pressed
//   key_press   : one-cycle press strobe
//   key_release : one-cycle release strobe
//   key_long    : one-cycle long-press strobe
// master = key source/consumer side, slave = key_filter_bank.
interface key_filter_bank_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        output key_in,
        input  key_state, key_press, key_release, key_long
    );

    modport slave (
        input  key_in,
        output key_state, key_press, key_release, key_long
    );
endinterface

// File: rtl/key_filter_chan.sv
// key_filter_chan: one key - 2-flop synchroniser, 4-state debounce FSM,
// filter counter and registered level/strobe outputs.
// Optional long-press detection when KEY_FILTER_BANK_LONG_PRESS_EN is defined.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   key_n              : raw active-low key pin (asynchronous)
//   evt                : registered level and strobes
module key_filter_chan
    import key_filter_pkg::*;
#(
    parameter logic [CNT_W-1:0]  CNT_MAX  = 24'd999_999,
    parameter logic [LONG_W-1:0] LONG_MAX = 26'd49_999_999
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    input  logic     key_n,
    output key_evt_t evt
);

    logic             sync1;
    logic             sync2;
    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             lvl_q;
    logic             press_q;
    logic             rls_q;
    logic             long_q;

    // Synchroniser, debounce FSM and its registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rls_q   <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            press_q <= 1'b0;
            rls_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sync2) begin
                        state <= PRESS_FILT;
                        cnt   <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (sync2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state   <= DOWN;
                        press_q <= 1'b1;
                        lvl_q   <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (sync2) begin
                        state <= REL_FILT;
                        cnt   <= '0;
                    end
                end
                REL_FILT: begin
                    if (!sync2) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        rls_q <= 1'b1;
                        lvl_q <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef KEY_FILTER_BANK_LONG_PRESS_EN
    logic [LONG_W-1:0] lcnt;
    logic              long_done;

    // Long-press timer: advances only while DOWN, so a release bounce
    // (REL_FILT -> DOWN) keeps the accumulated hold time. Cleared once the
    // press has fully ended (IDLE).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lcnt      <= '0;
            long_done <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state == DOWN) begin
                if (lcnt == LONG_MAX) begin
                    if (!long_done) begin
                        long_q    <= 1'b1;
                        long_done <= 1'b1;
                    end
                end else begin
                    lcnt <= lcnt + LONG_W'(1);
                end
            end else if (state == IDLE) begin
                lcnt      <= '0;
                long_done <= 1'b0;
            end
        end
    end
`else
    logic unused_long_max;
    assign unused_long_max = ^LONG_MAX;
    assign long_q          = 1'b0;
`endif

    assign evt = '{lvl: lvl_q, press: press_q, rls: rls_q, lng: long_q};

endmodule

// File: rtl/key_filter_bank.sv
// key_filter_bank: NUM_KEYS independent debounced push-button channels.
// Optional feature macro: KEY_FILTER_BANK_LONG_PRESS_EN (long-press strobe).
// Ports:
//   sys_clk   : system clock
//   sys_rst_n : async active-low reset
//   kif       : key_filter_bank_if.slave (key_in in; key_state, key_press,
//               key_release, key_long out)
module key_filter_bank
    import key_filter_pkg::*;
#(
    parameter int unsigned       NUM_KEYS = 4,
    parameter logic [CNT_W-1:0]  CNT_MAX  = 24'd999_999,
    parameter logic [LONG_W-1:0] LONG_MAX = 26'd49_999_999
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    key_filter_bank_if.slave     kif
);

    key_evt_t evt [NUM_KEYS];

    // One channel per key; no shared state between keys
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_filter_chan #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_chan (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_n     (kif.key_in[i]),
            .evt       (evt[i])
        );
    end

    // Spread per-key events back onto the bus vectors
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            kif.key_state[i]   = evt[i].lvl;
            kif.key_press[i]   = evt[i].press;
            kif.key_release[i] = evt[i].rls;
            kif.key_long[i]    = evt[i].lng;
        end
    end

endmodule
